sync_fifo_prog: RTL and testbench

Single-clock, parametrised FIFO; successor to the team's dual-clock FIFO for same-domain buffering between pipeline stages.
- Adds occupancy count, runtime-programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags.
- Selectable standard (registered read) or first-word-fall-through (FWFT) read mode.
- Depth is a power of two; storage is a flop/RAM array indexed by binary pointers with an extra wrap bit.

---
 rtl/sync_fifo_prog.sv | 135 +++++++++++++
 tb/tb_sync_fifo_prog.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
// The FWFT parameter selects a registered read port (0) or a
// first-word-fall-through read port (1).
// Optional build macro SYNC_FIFO_HWM_EN adds a registered high-water-mark
// output (hwm).
module sync_fifo_prog #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 3,
  parameter int FWFT   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wren,
  input  logic [DWIDTH-1:0] din,
  input  logic              rden,
  output logic [DWIDTH-1:0] dout,
  output logic              full,
  output logic              empty,
  input  logic [AWIDTH:0]   afull_th,
  input  logic [AWIDTH:0]   aempty_th,
  output logic              afull,
  output logic              aempty,
  output logic [AWIDTH:0]   level,
  output logic              ovf,
  output logic              udf,
  input  logic              clr_err
`ifdef SYNC_FIFO_HWM_EN
  ,
  output logic [AWIDTH:0]   hwm
`endif
);

  localparam int DEPTH = 1 << AWIDTH;

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [AWIDTH:0]   wptr_q, wptr_d;
  logic [AWIDTH:0]   rptr_q, rptr_d;
  logic [AWIDTH:0]   level_q, level_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              rd_acc, wr_acc;

  // Flags come straight from the registered pointers so they track the
  // state after the last edge without extra latency.
  assign empty  = (wptr_q == rptr_q);
  assign full   = (wptr_q[AWIDTH] != rptr_q[AWIDTH]) &&
                  (wptr_q[AWIDTH-1:0] == rptr_q[AWIDTH-1:0]);
  assign afull  = (level_q >= afull_th);
  assign aempty = (level_q <= aempty_th);
  assign level  = level_q;
  assign ovf    = ovf_q;
  assign udf    = udf_q;

  // A read frees a slot on the same edge, so a full FIFO still takes a
  // write when a read is accepted alongside it.
  assign rd_acc = rden & ~empty;
  assign wr_acc = wren & (~full | rd_acc);

  // Next-state for pointers, occupancy and sticky error flags.
  always_comb begin
    wptr_d  = wptr_q + {{AWIDTH{1'b0}}, wr_acc};
    rptr_d  = rptr_q + {{AWIDTH{1'b0}}, rd_acc};
    level_d = level_q;
    case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    // A fresh error in the clearing cycle keeps the flag set.
    ovf_d = ovf_q;
    if (clr_err) ovf_d = 1'b0;
    if (wren && !wr_acc) ovf_d = 1'b1;
    udf_d = udf_q;
    if (clr_err) udf_d = 1'b0;
    if (rden && empty) udf_d = 1'b1;
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage array; contents survive reset, only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wptr_q[AWIDTH-1:0]] <= din;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign dout = empty ? '0 : mem_q[rptr_q[AWIDTH-1:0]];
    end else begin : g_std
      logic [DWIDTH-1:0] dout_q;
      // Registered read port: load the head word on an accepted read.
      always_ff @(posedge clk) begin
        if (rst) dout_q <= '0;
        else if (rd_acc) dout_q <= mem_q[rptr_q[AWIDTH-1:0]];
      end
      assign dout = dout_q;
    end
  endgenerate

`ifdef SYNC_FIFO_HWM_EN
  logic [AWIDTH:0] hwm_q, hwm_d;

  // High-water mark follows the post-edge occupancy; clearing restarts it
  // from that occupancy.
  always_comb begin
    hwm_d = hwm_q;
    if (clr_err) hwm_d = level_d;
    else if (level_d > hwm_q) hwm_d = level_d;
  end

  // High-water-mark register.
  always_ff @(posedge clk) begin
    if (rst) hwm_q <= '0;
    else hwm_q <= hwm_d;
  end

  assign hwm = hwm_q;
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Self-checking bench for sync_fifo_prog: a standard-read and an FWFT
// instance share one stimulus stream and are compared every cycle against
// a queue-based reference model.
module tb_sync_fifo_prog;

  localparam int DW  = 32;
  localparam int AW  = 3;
  localparam int DEP = 8;

  logic          clk = 1'b0;
  logic          rst, wren, rden, clr_err;
  logic [DW-1:0] din;
  logic [AW:0]   afull_th, aempty_th;
  logic [DW-1:0] dout_s, dout_f;
  logic          full_s, empty_s, afull_s, aempty_s, ovf_s, udf_s;
  logic          full_f, empty_f, afull_f, aempty_f, ovf_f, udf_f;
  logic [AW:0]   level_s, level_f;
`ifdef SYNC_FIFO_HWM_EN
  logic [AW:0]   hwm_s, hwm_f;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  logic          m_ovf, m_udf;
  logic [DW-1:0] m_dout;
  int            m_hwm;

  always #5 clk = ~clk;

  sync_fifo_prog #(.DWIDTH(DW), .AWIDTH(AW), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wren(wren), .din(din), .rden(rden),
    .dout(dout_s), .full(full_s), .empty(empty_s),
    .afull_th(afull_th), .aempty_th(aempty_th),
    .afull(afull_s), .aempty(aempty_s), .level(level_s),
    .ovf(ovf_s), .udf(udf_s), .clr_err(clr_err)
`ifdef SYNC_FIFO_HWM_EN
    , .hwm(hwm_s)
`endif
  );

  sync_fifo_prog #(.DWIDTH(DW), .AWIDTH(AW), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wren(wren), .din(din), .rden(rden),
    .dout(dout_f), .full(full_f), .empty(empty_f),
    .afull_th(afull_th), .aempty_th(aempty_th),
    .afull(afull_f), .aempty(aempty_f), .level(level_f),
    .ovf(ovf_f), .udf(udf_f), .clr_err(clr_err)
`ifdef SYNC_FIFO_HWM_EN
    , .hwm(hwm_f)
`endif
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, advance the model, compare both DUTs.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r,
                      input logic c, input logic rs, input string tag);
    bit rdacc, wracc;
    int n;
    wren = w; din = d; rden = r; clr_err = c; rst = rs;
    @(posedge clk);
    if (rs) begin
      q.delete();
      m_ovf = 1'b0; m_udf = 1'b0; m_dout = '0; m_hwm = 0;
    end else begin
      rdacc = r && (q.size() != 0);
      wracc = w && ((q.size() < DEP) || rdacc);
      if (w && !wracc) m_ovf = 1'b1;
      else if (c) m_ovf = 1'b0;
      if (r && q.size() == 0) m_udf = 1'b1;
      else if (c) m_udf = 1'b0;
      if (rdacc) m_dout = q.pop_front();
      if (wracc) q.push_back(d);
      if (c) m_hwm = q.size();
      else if (q.size() > m_hwm) m_hwm = q.size();
    end
    #1;
    n = q.size();
    chk({tag, ".level"},  DW'(level_s),  DW'(n));
    chk({tag, ".empty"},  DW'(empty_s),  DW'(n == 0));
    chk({tag, ".full"},   DW'(full_s),   DW'(n == DEP));
    chk({tag, ".afull"},  DW'(afull_s),  DW'(n >= int'(afull_th)));
    chk({tag, ".aempty"}, DW'(aempty_s), DW'(n <= int'(aempty_th)));
    chk({tag, ".ovf"},    DW'(ovf_s),    DW'(m_ovf));
    chk({tag, ".udf"},    DW'(udf_s),    DW'(m_udf));
    chk({tag, ".dout_s"}, dout_s,        m_dout);
    chk({tag, ".dout_f"}, dout_f,        (n == 0) ? '0 : q[0]);
    chk({tag, ".lvl_f"},  DW'({level_f, full_f, empty_f, afull_f, aempty_f, ovf_f, udf_f}),
                          DW'({level_s, full_s, empty_s, afull_s, aempty_s, ovf_s, udf_s}));
`ifdef SYNC_FIFO_HWM_EN
    chk({tag, ".hwm_s"},  DW'(hwm_s),    DW'(m_hwm));
    chk({tag, ".hwm_f"},  DW'(hwm_f),    DW'(m_hwm));
`endif
  endtask

  initial begin
    logic [DW-1:0] v;
    rst = 1'b1; wren = 1'b0; rden = 1'b0; clr_err = 1'b0; din = '0;
    afull_th = 4'd6; aempty_th = 4'd1;

    // 1: reset then idle
    step(0, 0, 0, 0, 1, "rst");
    step(0, 0, 0, 0, 1, "rst");
    step(0, 0, 0, 0, 0, "idle");
    chk("idle.dout_const", dout_s, 32'h0);

    // 2: fill to full, overflow write, drain, underflow read
    for (int i = 1; i <= 8; i++) step(1, DW'(i), 0, 0, 0, "fill");
    chk("fill.full_const", DW'(full_s), 32'd1);
    step(1, 32'h9, 0, 0, 0, "ovfw");
    chk("ovfw.ovf_const", DW'(ovf_s), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      step(0, 0, 1, 0, 0, "drain");
      chk("drain.order", dout_s, DW'(i));
    end
    step(0, 0, 1, 0, 0, "udfr");
    chk("udfr.hold", dout_s, 32'h8);
    chk("udfr.udf_const", DW'(udf_s), 32'd1);

    // 3: simultaneous write+read while full, pointer wrap
    step(0, 0, 0, 1, 0, "clr");
    for (int i = 0; i < 8; i++) step(1, 32'h100 + DW'(i), 0, 0, 0, "refill");
    for (int i = 0; i < 4; i++) step(1, 32'hA + DW'(i), 1, 0, 0, "wrrd_full");
    chk("wrrd_full.level", DW'(level_s), 32'd8);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0, "drain2");
    chk("drain2.last", dout_s, 32'hD);

    // 4: fall-through of a single word
    step(1, 32'hDEADBEEF, 0, 0, 0, "fwft_wr");
    chk("fwft_wr.dout", dout_f, 32'hDEADBEEF);
    step(0, 0, 1, 0, 0, "fwft_rd");
    chk("fwft_rd.dout", dout_f, 32'h0);

    // 5: random write/read pairs, then clear
    for (int i = 0; i < 50; i++) begin
      v = $urandom;
      step(1, v, 0, 0, 0, "pair_w");
      step(0, 0, 1, 0, 0, "pair_r");
      chk("pair.data", dout_s, v);
    end
    step(0, 0, 0, 1, 0, "pair_clr");

    // Random mixed traffic, including thresholds above DEPTH
    afull_th = 4'd9; aempty_th = 4'd8;
    for (int i = 0; i < 150; i++) begin
      if (i == 75) begin afull_th = 4'd3; aempty_th = 4'd0; end
      step(1'($urandom), $urandom, 1'($urandom), ($urandom_range(0, 15) == 0),
           0, "rand");
    end
    afull_th = 4'd6; aempty_th = 4'd1;
    step(0, 0, 0, 1, 0, "rand_clr");
    while (q.size() != 0) step(0, 0, 1, 0, 0, "rand_drain");
    step(0, 0, 0, 1, 0, "rand_clr2");

    // 6: high-water mark, clear, reset mid-fill
    for (int i = 0; i < 5; i++) step(1, $urandom, 0, 0, 0, "hwm_fill");
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, "hwm_drain");
    step(0, 0, 0, 1, 0, "hwm_clr");
    for (int i = 0; i < 3; i++) step(1, $urandom, 0, 0, 0, "hwm_fill3");
    step(0, 0, 0, 0, 1, "midrst");
    chk("midrst.level", DW'(level_s), 32'd0);
    step(0, 0, 0, 0, 0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
